rptr_empty_ctrl: RTL and testbench

//  Read-domain pointer/empty controller of the async FIFO; read-side counterpart of the write pointer/full logic.

---
 rtl/rptr_empty_ctrl.sv | 110 +++++++++++
 tb/tb_rptr_empty_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer and empty controller for the async FIFO: binary/Gray read pointers,
// registered empty and almost-empty flags, read count, underflow flag and read-data-valid strobe.
module rptr_empty_ctrl #(
   parameter int unsigned ADDRESS_WIDTH = 4,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned SOFT_RESET    = 3,
   parameter int unsigned STICKY_ERROR  = 0,
   parameter int unsigned PIPE_READ     = 0,
   parameter int unsigned AEMPTY_LVL    = 2
) (
   input  logic                     rclk,
   input  logic                     hw_rst,
   input  logic                     sw_rst,
   input  logic                     rinc,
   input  logic [ADDRESS_WIDTH:0]   rq2_wptr,
   output logic [ADDRESS_WIDTH-1:0] raddr,
   output logic [ADDRESS_WIDTH:0]   rptr,
   output logic                     rempty,
   output logic                     raempty,
   output logic [ADDRESS_WIDTH:0]   rd_count,
   output logic                     rd_underflow,
   output logic                     rd_valid
);

   localparam int unsigned   PW         = ADDRESS_WIDTH + 1;
   localparam logic [PW-1:0] AEMPTY_THR = PW'(AEMPTY_LVL);
   localparam logic          SOFT_EN    = (SOFT_RESET == 1) || (SOFT_RESET == 3);

   if (DEPTH != (32'd1 << ADDRESS_WIDTH)) begin : g_depth_chk
      $error("rptr_empty_ctrl: DEPTH must equal 2**ADDRESS_WIDTH");
   end

   logic [PW-1:0] r_rbin;
   logic [PW-1:0] r_rptr;
   logic          r_rempty;
   logic          r_raempty;
   logic [PW-1:0] r_rd_count;
   logic          r_rd_underflow;
   logic          r_rd_valid;
   logic          r_rinc_r;

   logic          w_sw_rst;
   logic          w_req;
   logic          w_accept;
   logic          w_err;
   logic [PW-1:0] w_rbin_nxt;
   logic [PW-1:0] w_rgray_nxt;
   logic [PW-1:0] w_wbin_s;
   logic [PW-1:0] w_level;
   logic          w_empty_nxt;

   assign w_sw_rst    = sw_rst & SOFT_EN;
   assign w_req       = (PIPE_READ != 0) ? r_rinc_r : rinc;
   assign w_accept    = w_req & ~r_rempty;
   assign w_err       = w_req & r_rempty;
   assign w_rbin_nxt  = r_rbin + PW'(w_accept);
   assign w_rgray_nxt = (w_rbin_nxt >> 1) ^ w_rbin_nxt;
   assign w_empty_nxt = (w_rgray_nxt == rq2_wptr);

   // Gray-to-binary of the synchronized write pointer: bit i is the XOR of bits i and above
   always_comb begin
      w_wbin_s = '0;
      for (int i = 0; i < int'(PW); i++) begin
         w_wbin_s[i] = ^(rq2_wptr >> i);
      end
   end

   assign w_level = w_wbin_s - w_rbin_nxt;

   always_ff @(posedge rclk or posedge hw_rst) begin
      if (hw_rst) begin
         r_rbin         <= '0;
         r_rptr         <= '0;
         r_rempty       <= 1'b1;
         r_raempty      <= 1'b1;
         r_rd_count     <= '0;
         r_rd_underflow <= 1'b0;
         r_rd_valid     <= 1'b0;
         r_rinc_r       <= 1'b0;
      end else if (w_sw_rst) begin
         r_rbin         <= '0;
         r_rptr         <= '0;
         r_rempty       <= 1'b1;
         r_raempty      <= 1'b1;
         r_rd_count     <= '0;
         r_rd_underflow <= 1'b0;
         r_rd_valid     <= 1'b0;
         r_rinc_r       <= 1'b0;
      end else begin
         r_rinc_r       <= rinc;
         r_rbin         <= w_rbin_nxt;
         r_rptr         <= w_rgray_nxt;
         r_rempty       <= w_empty_nxt;
         // empty forces almost-empty even if the level arithmetic disagreed
         r_raempty      <= w_empty_nxt | (w_level <= AEMPTY_THR);
         r_rd_count     <= r_rd_count + PW'(w_accept);
         r_rd_valid     <= w_accept;
         r_rd_underflow <= (STICKY_ERROR != 0) ? (r_rd_underflow | w_err) : w_err;
      end
   end

   assign raddr        = r_rbin[ADDRESS_WIDTH-1:0];
   assign rptr         = r_rptr;
   assign rempty       = r_rempty;
   assign raempty      = r_raempty;
   assign rd_count     = r_rd_count;
   assign rd_underflow = r_rd_underflow;
   assign rd_valid     = r_rd_valid;

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Directed bench for rptr_empty_ctrl: default instance plus a sticky-error,
// soft-reset-ignored, pipelined-read instance sharing clock and hardware reset.
module tb_rptr_empty_ctrl;

   logic       clk = 1'b0;
   logic       hw_rst;
   int         errors = 0;
   int         checks = 0;

   // instance a: defaults (SOFT_RESET=3, STICKY_ERROR=0, PIPE_READ=0)
   logic       a_sw_rst, a_rinc;
   logic [4:0] a_wptr;
   logic [3:0] a_raddr;
   logic [4:0] a_rptr, a_cnt;
   logic       a_empty, a_aempty, a_uf, a_valid;

   // instance b: SOFT_RESET=0, STICKY_ERROR=1, PIPE_READ=1
   logic       b_sw_rst, b_rinc;
   logic [4:0] b_wptr;
   logic [3:0] b_raddr;
   logic [4:0] b_rptr, b_cnt;
   logic       b_empty, b_aempty, b_uf, b_valid;

   always #5 clk = ~clk;

   rptr_empty_ctrl u_dut_a (
      .rclk(clk), .hw_rst(hw_rst), .sw_rst(a_sw_rst), .rinc(a_rinc), .rq2_wptr(a_wptr),
      .raddr(a_raddr), .rptr(a_rptr), .rempty(a_empty), .raempty(a_aempty),
      .rd_count(a_cnt), .rd_underflow(a_uf), .rd_valid(a_valid)
   );

   rptr_empty_ctrl #(
      .SOFT_RESET(0), .STICKY_ERROR(1), .PIPE_READ(1)
   ) u_dut_b (
      .rclk(clk), .hw_rst(hw_rst), .sw_rst(b_sw_rst), .rinc(b_rinc), .rq2_wptr(b_wptr),
      .raddr(b_raddr), .rptr(b_rptr), .rempty(b_empty), .raempty(b_aempty),
      .rd_count(b_cnt), .rd_underflow(b_uf), .rd_valid(b_valid)
   );

   // advance one rising edge and settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      hw_rst = 1'b1; a_sw_rst = 1'b0; a_rinc = 1'b0; a_wptr = 5'd0;
      b_sw_rst = 1'b0; b_rinc = 1'b0; b_wptr = 5'd0;
      tick(); tick();
      checks++; if ({a_empty, a_aempty, a_rptr, a_raddr, a_cnt, a_uf, a_valid} !== {2'b11, 5'd0, 4'd0, 5'd0, 2'b00})
         begin errors++; $display("FAIL reset_init got=%b exp=%b", {a_empty, a_aempty, a_rptr, a_raddr, a_cnt, a_uf, a_valid}, {2'b11, 16'd0}); end
      hw_rst = 1'b0;
      // one word available, read it so state differs from reset
      a_wptr = 5'b00001;
      tick();
      checks++; if (a_empty !== 1'b0) begin errors++; $display("FAIL reset_prep_empty got=%b exp=0", a_empty); end
      a_rinc = 1'b1;
      tick();
      a_rinc = 1'b0;
      checks++; if ({a_rptr, a_cnt, a_valid, a_empty} !== {5'd1, 5'd1, 1'b1, 1'b1})
         begin errors++; $display("FAIL reset_prep_read got=%b exp=%b", {a_rptr, a_cnt, a_valid, a_empty}, {5'd1, 5'd1, 2'b11}); end
      // assert reset between edges: outputs must clear without a clock edge
      #2 hw_rst = 1'b1;
      #1;
      checks++; if ({a_empty, a_aempty, a_rptr, a_raddr, a_cnt, a_uf, a_valid} !== {2'b11, 5'd0, 4'd0, 5'd0, 2'b00})
         begin errors++; $display("FAIL reset_async got=%b exp=%b", {a_empty, a_aempty, a_rptr, a_raddr, a_cnt, a_uf, a_valid}, {2'b11, 16'd0}); end
      a_wptr = 5'd0;
      tick();
      hw_rst = 1'b0;
      tick();
   endtask

   task automatic test_drain();
      a_wptr = 5'b00010;   // Gray of binary 3
      tick();
      checks++; if ({a_empty, a_aempty} !== 2'b00) begin errors++; $display("FAIL drain_flags_before got=%b exp=00", {a_empty, a_aempty}); end
      for (int i = 0; i < 3; i++) begin
         a_rinc = 1'b1;
         checks++; if (a_raddr !== 4'(i)) begin errors++; $display("FAIL drain_raddr%0d got=%0d exp=%0d", i, a_raddr, i); end
         tick();
         checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL drain_valid%0d got=%b exp=1", i, a_valid); end
         checks++; if (a_empty !== (i == 2)) begin errors++; $display("FAIL drain_empty%0d got=%b exp=%b", i, a_empty, i == 2); end
      end
      a_rinc = 1'b0;
      checks++; if ({a_cnt, a_rptr, a_raddr, a_aempty} !== {5'd3, 5'b00010, 4'd3, 1'b1})
         begin errors++; $display("FAIL drain_final got=%b exp=%b", {a_cnt, a_rptr, a_raddr, a_aempty}, {5'd3, 5'b00010, 4'd3, 1'b1}); end
      tick();
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_off got=%b exp=0", a_valid); end
   endtask

   task automatic test_underflow();
      a_rinc = 1'b1;
      tick();
      a_rinc = 1'b0;
      checks++; if ({a_uf, a_rptr, a_cnt, a_valid} !== {1'b1, 5'b00010, 5'd3, 1'b0})
         begin errors++; $display("FAIL uf_pulse got=%b exp=%b", {a_uf, a_rptr, a_cnt, a_valid}, {1'b1, 5'b00010, 5'd3, 1'b0}); end
      tick();
      checks++; if ({a_uf, a_rptr} !== {1'b0, 5'b00010}) begin errors++; $display("FAIL uf_pulse_end got=%b exp=%b", {a_uf, a_rptr}, {1'b0, 5'b00010}); end
   endtask

   task automatic test_wrap();
      a_sw_rst = 1'b1; a_wptr = 5'd0;
      tick();
      a_sw_rst = 1'b0;
      a_wptr = 5'b11000;   // Gray of binary 16: full lap ahead
      tick();
      checks++; if (a_empty !== 1'b0) begin errors++; $display("FAIL wrap_full_empty got=%b exp=0", a_empty); end
      for (int i = 0; i < 16; i++) begin
         a_rinc = 1'b1;
         if (i == 15) begin
            checks++; if (a_raddr !== 4'd15) begin errors++; $display("FAIL wrap_raddr15 got=%0d exp=15", a_raddr); end
         end
         tick();
      end
      a_rinc = 1'b0;
      checks++; if ({a_raddr, a_rptr, a_empty, a_cnt} !== {4'd0, 5'b11000, 1'b1, 5'd16})
         begin errors++; $display("FAIL wrap_lap got=%b exp=%b", {a_raddr, a_rptr, a_empty, a_cnt}, {4'd0, 5'b11000, 1'b1, 5'd16}); end
      a_wptr = 5'b11001;   // Gray of binary 17
      tick();
      checks++; if (a_empty !== 1'b0) begin errors++; $display("FAIL wrap_refill got=%b exp=0", a_empty); end
      a_rinc = 1'b1;
      tick();
      a_rinc = 1'b0;
      checks++; if ({a_raddr, a_rptr, a_empty} !== {4'd1, 5'b11001, 1'b1})
         begin errors++; $display("FAIL wrap_second got=%b exp=%b", {a_raddr, a_rptr, a_empty}, {4'd1, 5'b11001, 1'b1}); end
   endtask

   task automatic test_almost_empty();
      a_wptr = 5'b11110;   // Gray of binary 20, read side at 17: level 3
      tick();
      checks++; if ({a_empty, a_aempty} !== 2'b00) begin errors++; $display("FAIL aempty_lvl3 got=%b exp=00", {a_empty, a_aempty}); end
      a_rinc = 1'b1;
      tick();
      a_rinc = 1'b0;
      checks++; if ({a_empty, a_aempty, a_raddr} !== {2'b01, 4'd2}) begin errors++; $display("FAIL aempty_lvl2 got=%b exp=%b", {a_empty, a_aempty, a_raddr}, {2'b01, 4'd2}); end
   endtask

   task automatic test_sw_reset();
      // instance a honours soft reset even with a read requested
      a_rinc = 1'b1; a_sw_rst = 1'b1; a_wptr = 5'd0;
      tick();
      a_rinc = 1'b0; a_sw_rst = 1'b0;
      checks++; if ({a_empty, a_aempty, a_rptr, a_raddr, a_cnt, a_uf, a_valid} !== {2'b11, 5'd0, 4'd0, 5'd0, 2'b00})
         begin errors++; $display("FAIL swrst_clear got=%b exp=%b", {a_empty, a_aempty, a_rptr, a_raddr, a_cnt, a_uf, a_valid}, {2'b11, 16'd0}); end
      tick();
      checks++; if ({a_empty, a_valid} !== 2'b10) begin errors++; $display("FAIL swrst_hold got=%b exp=10", {a_empty, a_valid}); end
   endtask

   task automatic test_pipe_read();
      logic [3:0] exp_raddr [5];
      logic       exp_valid [5];
      exp_raddr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
      exp_valid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      b_wptr = 5'b00010;
      tick();
      checks++; if (b_empty !== 1'b0) begin errors++; $display("FAIL pipe_empty_before got=%b exp=0", b_empty); end
      for (int i = 0; i < 5; i++) begin
         b_rinc = (i < 3);
         tick();
         checks++; if ({b_raddr, b_valid} !== {exp_raddr[i], exp_valid[i]})
            begin errors++; $display("FAIL pipe_step%0d got=%b exp=%b", i, {b_raddr, b_valid}, {exp_raddr[i], exp_valid[i]}); end
         if (i == 3) begin
            checks++; if ({b_cnt, b_rptr, b_empty} !== {5'd3, 5'b00010, 1'b1})
               begin errors++; $display("FAIL pipe_final got=%b exp=%b", {b_cnt, b_rptr, b_empty}, {5'd3, 5'b00010, 1'b1}); end
         end
      end
      b_rinc = 1'b0;
   endtask

   task automatic test_sticky_underflow();
      b_rinc = 1'b1;
      tick();
      b_rinc = 1'b0;
      checks++; if (b_uf !== 1'b0) begin errors++; $display("FAIL sticky_early got=%b exp=0", b_uf); end
      tick();
      checks++; if (b_uf !== 1'b1) begin errors++; $display("FAIL sticky_set got=%b exp=1", b_uf); end
      tick(); tick(); tick();
      checks++; if ({b_uf, b_rptr, b_cnt} !== {1'b1, 5'b00010, 5'd3})
         begin errors++; $display("FAIL sticky_hold got=%b exp=%b", {b_uf, b_rptr, b_cnt}, {1'b1, 5'b00010, 5'd3}); end
   endtask

   task automatic test_back_to_back_sw_ignored();
      b_wptr = 5'b00111;   // Gray of binary 5: two more words
      tick();
      checks++; if (b_empty !== 1'b0) begin errors++; $display("FAIL ign_refill got=%b exp=0", b_empty); end
      b_rinc = 1'b1; b_sw_rst = 1'b1;
      tick();
      tick();
      checks++; if ({b_raddr, b_cnt, b_uf, b_valid} !== {4'd4, 5'd4, 2'b11})
         begin errors++; $display("FAIL ign_mid got=%b exp=%b", {b_raddr, b_cnt, b_uf, b_valid}, {4'd4, 5'd4, 2'b11}); end
      b_rinc = 1'b0; b_sw_rst = 1'b0;
      tick();
      checks++; if ({b_raddr, b_cnt, b_empty, b_rptr} !== {4'd5, 5'd5, 1'b1, 5'b00111})
         begin errors++; $display("FAIL ign_final got=%b exp=%b", {b_raddr, b_cnt, b_empty, b_rptr}, {4'd5, 5'd5, 1'b1, 5'b00111}); end
   endtask

   initial begin
      test_reset();
      test_drain();
      test_underflow();
      test_wrap();
      test_almost_empty();
      test_sw_reset();
      test_pipe_read();
      test_sticky_underflow();
      test_back_to_back_sw_ignored();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
